vend_sequencer: RTL
===================

# vend_sequencer

Physical-dispense controller behind the drink-vending FSM. On a vend request it runs the drink motor for a fixed time, then pays out the requested change one coin at a time from two coin hoppers (1-ruble and 2-ruble). It tracks hopper stock, flags short change, and tells the coin front end when coins may be accepted. It sits between the vending FSM's take_ur_drink/give_N_rubles_back outputs and the motor and ejector actuators.

## Interface
Parameters:
- MOTOR_CYCLES, 8: cycles motor_on stays high per vend (≥1).
- PULSE_CYCLES, 2: cycles an eject strobe stays high per coin (≥1).
- GAP_CYCLES, 2: idle cycles after each coin pulse (≥1).
- STOCK_W, 4: width of each hopper counter.
- STOCK_INIT, 15: both hopper counts after reset (≤ 2^STOCK_W−1).

Ports:
- CLK, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-high.
- vend_req, in, 1: vend request, one-cycle pulse; sampled only in IDLE.
- change, in, 3: rubles to return, sampled with vend_req; values >4 are clamped to 4.
- refill_1, in, 1: per-cycle pulse, adds one coin to the 1-ruble hopper.
- refill_2, in, 1: per-cycle pulse, adds one coin to the 2-ruble hopper.
- accept_coins, out, 1: high only in IDLE.
- motor_on, out, 1: drink motor drive.
- eject_1, out, 1: 1-ruble ejector strobe.
- eject_2, out, 1: 2-ruble ejector strobe.
- stock_1, out, STOCK_W: 1-ruble hopper count.
- stock_2, out, STOCK_W: 2-ruble hopper count.
- done, out, 1: one-cycle pulse when a vend completes.
- short_change, out, 1: sticky; the last vend could not pay the full change.

## Operation
- States: IDLE, MOTOR, EJECT, GAP, DONE. A registered cycle counter times MOTOR, EJECT and GAP.
- IDLE:
  - vend_req=1: latch remaining=min(change,4), clear short_change, go to MOTOR, load counter.
  - vend_req outside IDLE is ignored.
- MOTOR: motor_on=1 for exactly MOTOR_CYCLES cycles, then a coin decision.
- Coin decision, evaluated on the last cycle of MOTOR or GAP:
  - remaining=0: go to DONE.
  - remaining≥2 and stock_2>0: select a 2-ruble coin.
  - otherwise, stock_1>0: select a 1-ruble coin.
  - otherwise: set short_change and go to DONE.
  - On selecting a coin: go to EJECT, latch the coin type, decrement the matching stock, subtract the coin value from remaining.
- EJECT: the selected eject_x is high for PULSE_CYCLES cycles, then go to GAP. eject_1 and eject_2 are never both high.
- GAP: all strobes low for GAP_CYCLES cycles, then a coin decision.
- DONE: done=1 for one cycle, then IDLE. short_change holds until the next accepted vend_req.
- Refill:
  - Accepted in any state; the stock increments and saturates at 2^STOCK_W−1.
  - A refill in the same cycle as a decrement of the same hopper leaves the count unchanged.
- Reset (asynchronous, any time, including mid-vend):
  - State goes to IDLE; motor_on, eject_1, eject_2, done and short_change go to 0; accept_coins goes to 1.
  - stock_1 and stock_2 go to STOCK_INIT; remaining and the counter go to 0.
  - An in-progress vend is abandoned, not resumed.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- vend_req is sampled at edge 0. motor_on is high in cycles 1..MOTOR_CYCLES. accept_coins drops in cycle 1.
- Each coin costs PULSE_CYCLES+GAP_CYCLES cycles.
- With defaults, done rises in cycle 9+4·n, where n is the number of coins paid. IDLE resumes the following cycle.
- A stock decrement is visible on stock_x in the first EJECT cycle.

## Test plan
- Reset mid-MOTOR (change=2): all outputs go to their reset values immediately; stocks=15; the next vend_req is accepted normally.
- change=0, stocks 15/15: motor_on in cycles 1–8; done in cycle 9; no eject strobes; stocks unchanged.
- change=3, stocks 15/15: eject_2 in cycles 9–10; eject_1 in cycles 13–14; done in cycle 17; stock_2=14, stock_1=14; short_change=0.
- change=4, stock_2=0, stock_1=3: three eject_1 pulses; done in cycle 21; short_change=1; stock_1=0.
- change=7: clamped to 4; two eject_2 pulses; done in cycle 17. vend_req pulsed mid-EJECT is ignored, with no second motor run.
- Refill at saturation: refill_1 held for 3 cycles with stock_1=15 keeps stock_1=15. refill_2 in the same cycle as a 2-ruble decrement keeps stock_2 unchanged.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// Vend-sequencer signal bundle: requests and refills in, actuator strobes and stock counts out.
// master drives the request side; slave is the sequencer itself.
interface vend_sequencer_if #(
    parameter int STOCK_W = 4
) ();
    logic               vend_req;
    logic [2:0]         change;
    logic               refill_1;
    logic               refill_2;
    logic               accept_coins;
    logic               motor_on;
    logic               eject_1;
    logic               eject_2;
    logic [STOCK_W-1:0] stock_1;
    logic [STOCK_W-1:0] stock_2;
    logic               done;
    logic               short_change;

    modport master (
        output vend_req, change, refill_1, refill_2,
        input  accept_coins, motor_on, eject_1, eject_2,
        input  stock_1, stock_2, done, short_change
    );

    modport slave (
        input  vend_req, change, refill_1, refill_2,
        output accept_coins, motor_on, eject_1, eject_2,
        output stock_1, stock_2, done, short_change
    );
endinterface

// File: rtl/vend_sequencer.sv
// Dispense sequencer: runs the drink motor, then pays change coin by coin from two hoppers.
// done arrives MOTOR_CYCLES+1+n*(PULSE+GAP) cycles after vend_req; no backpressure, requests outside IDLE are dropped.
module vend_sequencer #(
    parameter int MOTOR_CYCLES = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 15
) (
    input  logic             CLK,
    input  logic             reset,
    vend_sequencer_if.slave  bus
);

    localparam int MAX_A  = (MOTOR_CYCLES > PULSE_CYCLES) ? MOTOR_CYCLES : PULSE_CYCLES;
    localparam int MAX_C  = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0]   MOTOR_LOAD = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
    localparam logic [STOCK_W-1:0] STOCK_RST  = STOCK_W'(STOCK_INIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOTOR = 3'd1,
        EJECT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         rem_q, rem_d;
    logic               coin2_q, coin2_d;
    logic               short_q, short_d;
    logic [STOCK_W-1:0] stock1_q, stock1_d;
    logic [STOCK_W-1:0] stock2_q, stock2_d;
    logic               motor_q, ej1_q, ej2_q, done_q, accept_q;

    logic               cnt_last;
    logic               dec1, dec2;

    assign cnt_last = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        coin2_d = coin2_q;
        short_d = short_q;
        dec1    = 1'b0;
        dec2    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.vend_req) begin
                    rem_d   = (bus.change > 3'd4) ? 3'd4 : bus.change;
                    short_d = 1'b0;
                    state_d = MOTOR;
                    cnt_d   = MOTOR_LOAD;
                end
            end
            MOTOR, GAP: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rem_q == 3'd0) begin
                    state_d = DONE;
                end else if ((rem_q >= 3'd2) && (stock2_q != '0)) begin
                    state_d = EJECT;
                    coin2_d = 1'b1;
                    dec2    = 1'b1;
                    rem_d   = rem_q - 3'd2;
                    cnt_d   = PULSE_LOAD;
                end else if (stock1_q != '0) begin
                    state_d = EJECT;
                    coin2_d = 1'b0;
                    dec1    = 1'b1;
                    rem_d   = rem_q - 3'd1;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    short_d = 1'b1;
                    state_d = DONE;
                end
            end
            EJECT: begin
                if (cnt_last) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A refill coinciding with a payout of the same hopper cancels out.
    always_comb begin
        stock1_d = stock1_q;
        if (bus.refill_1 && !dec1) begin
            if (stock1_q != STOCK_MAX) stock1_d = stock1_q + 1'b1;
        end else if (dec1 && !bus.refill_1) begin
            stock1_d = stock1_q - 1'b1;
        end
    end

    always_comb begin
        stock2_d = stock2_q;
        if (bus.refill_2 && !dec2) begin
            if (stock2_q != STOCK_MAX) stock2_d = stock2_q + 1'b1;
        end else if (dec2 && !bus.refill_2) begin
            stock2_d = stock2_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            coin2_q  <= 1'b0;
            short_q  <= 1'b0;
            stock1_q <= STOCK_RST;
            stock2_q <= STOCK_RST;
            motor_q  <= 1'b0;
            ej1_q    <= 1'b0;
            ej2_q    <= 1'b0;
            done_q   <= 1'b0;
            accept_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            coin2_q  <= coin2_d;
            short_q  <= short_d;
            stock1_q <= stock1_d;
            stock2_q <= stock2_d;
            motor_q  <= (state_d == MOTOR);
            ej1_q    <= (state_d == EJECT) && !coin2_d;
            ej2_q    <= (state_d == EJECT) && coin2_d;
            done_q   <= (state_d == DONE);
            accept_q <= (state_d == IDLE);
        end
    end

    assign bus.accept_coins = accept_q;
    assign bus.motor_on     = motor_q;
    assign bus.eject_1      = ej1_q;
    assign bus.eject_2      = ej2_q;
    assign bus.done         = done_q;
    assign bus.short_change = short_q;
    assign bus.stock_1      = stock1_q;
    assign bus.stock_2      = stock2_q;

endmodule
